// File: rtl/arp_resolver.sv
// Resolves a next-hop IPv4 address to a MAC via the ARP cache, issuing ARP
// requests on a miss and re-querying after each matching cache write or timeout.
module arp_resolver #(
   parameter int RETRY_COUNT    = 4,
   parameter int RETRY_INTERVAL = 250000000,
   parameter int TIMER_WIDTH    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lookup_req_valid,
   output logic        lookup_req_ready,
   input  logic [31:0] lookup_req_ip,
   output logic        lookup_resp_valid,
   input  logic        lookup_resp_ready,
   output logic        lookup_resp_error,
   output logic [47:0] lookup_resp_mac,
   output logic        cache_query_valid,
   input  logic        cache_query_ready,
   output logic [31:0] cache_query_ip,
   input  logic        cache_resp_valid,
   output logic        cache_resp_ready,
   input  logic        cache_resp_error,
   input  logic [47:0] cache_resp_mac,
   input  logic        snoop_write_valid,
   input  logic [31:0] snoop_write_ip,
   output logic        arp_tx_valid,
   input  logic        arp_tx_ready,
   output logic [31:0] arp_tx_target_ip,
   input  logic [31:0] local_ip,
   input  logic [31:0] gateway_ip,
   input  logic [31:0] subnet_mask
);

   localparam int CNT_W = $clog2(RETRY_COUNT + 1);

   typedef enum logic [2:0] {
      IDLE, QUERY, WAIT_CACHE, SEND_ARP, WAIT_REPLY, RESPOND
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            target_q, target_d;
   logic [CNT_W-1:0]       retry_q, retry_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [47:0]            mac_q, mac_d;
   logic                   err_q, err_d;
   logic                   req_ready_q, query_valid_q, cresp_ready_q, arp_valid_q, resp_valid_q;

   logic req_fire, query_fire, cresp_fire, arp_fire, resp_fire;
   logic is_bcast, off_subnet, snoop_hit;

   assign req_fire   = lookup_req_valid & req_ready_q;
   assign query_fire = query_valid_q & cache_query_ready;
   assign cresp_fire = cache_resp_valid & cresp_ready_q;
   assign arp_fire   = arp_valid_q & arp_tx_ready;
   assign resp_fire  = resp_valid_q & lookup_resp_ready;

   assign is_bcast   = (lookup_req_ip == 32'hFFFF_FFFF) ||
                       ((lookup_req_ip & ~subnet_mask) == ~subnet_mask);
   assign off_subnet = ((lookup_req_ip ^ local_ip) & subnet_mask) != 32'd0;
   assign snoop_hit  = snoop_write_valid && (snoop_write_ip == target_q);

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      retry_d  = retry_q;
      timer_d  = timer_q;
      mac_d    = mac_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: if (req_fire) begin
            if (is_bcast) begin
               mac_d   = 48'hFFFF_FFFF_FFFF;
               err_d   = 1'b0;
               state_d = RESPOND;
            end else begin
               target_d = off_subnet ? gateway_ip : lookup_req_ip;
               retry_d  = CNT_W'(RETRY_COUNT);
               state_d  = QUERY;
            end
         end
         QUERY: if (query_fire) state_d = WAIT_CACHE;
         WAIT_CACHE: if (cresp_fire) begin
            if (!cache_resp_error) begin
               mac_d   = cache_resp_mac;
               err_d   = 1'b0;
               state_d = RESPOND;
            end else if (retry_q == '0) begin
               mac_d   = '0;
               err_d   = 1'b1;
               state_d = RESPOND;
            end else begin
               state_d = SEND_ARP;
            end
         end
         SEND_ARP: if (arp_fire) begin
            retry_d = retry_q - CNT_W'(1);
            timer_d = TIMER_WIDTH'(RETRY_INTERVAL - 1);
            state_d = WAIT_REPLY;
         end
         WAIT_REPLY: begin
            // A matching cache write wins over expiry landing in the same cycle.
            if (snoop_hit || timer_q == '0) state_d = QUERY;
            else                            timer_d = timer_q - TIMER_WIDTH'(1);
         end
         RESPOND: if (resp_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: handshake outputs are registered from the next state, so each one is
   // high exactly while its state is held and changes one cycle after the fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         target_q      <= '0;
         retry_q       <= '0;
         timer_q       <= '0;
         mac_q         <= '0;
         err_q         <= 1'b0;
         req_ready_q   <= 1'b0;
         query_valid_q <= 1'b0;
         cresp_ready_q <= 1'b0;
         arp_valid_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         retry_q       <= retry_d;
         timer_q       <= timer_d;
         mac_q         <= mac_d;
         err_q         <= err_d;
         req_ready_q   <= (state_d == IDLE);
         query_valid_q <= (state_d == QUERY);
         cresp_ready_q <= (state_d == WAIT_CACHE);
         arp_valid_q   <= (state_d == SEND_ARP);
         resp_valid_q  <= (state_d == RESPOND);
      end
   end

   assign lookup_req_ready  = req_ready_q;
   assign lookup_resp_valid = resp_valid_q;
   assign lookup_resp_error = err_q;
   assign lookup_resp_mac   = mac_q;
   assign cache_query_valid = query_valid_q;
   assign cache_query_ip    = target_q;
   assign cache_resp_ready  = cresp_ready_q;
   assign arp_tx_valid      = arp_valid_q;
   assign arp_tx_target_ip  = target_q;

endmodule
